// File: rtl/soc_uart_rx.sv
// UART receiver peripheral: 8N1 deserialiser feeding a byte FIFO, drained over the
// SoC valid/ready bus slave protocol, with an optional level interrupt.
module soc_uart_rx #(
  parameter int unsigned UART_CLK_HZ = 27000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk_cpu,
  input  logic        n_reset,
  input  logic        rx_pin,
  input  logic        sel,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq
);

  localparam int unsigned CLKS_PER_BIT = UART_CLK_HZ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned CW           = AW + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;

  rx_state_t        state, state_next;
  logic             rx_meta, rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick_half, tick_bit;
  logic             cnt_clr, idx_clr, shift_en, rx_push, frame_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_full, not_empty;
  logic             overrun, frame_err, irq_en;

  logic             bus_access, bus_read, bus_write_lo;
  logic [1:0]       reg_sel;
  logic             pop, push, overrun_set, w1c;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_sync <= rx_meta;
    end
  end

  assign tick_half = (cnt == HALF_LAST);
  assign tick_bit  = (cnt == BIT_LAST);

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (!rx_sync) state_next = S_START;
      S_START:     if (tick_half) state_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:      if (tick_bit && bit_idx == 3'd7) state_next = S_STOP;
      S_STOP:      if (tick_bit) state_next = rx_sync ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_sync) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Counter is held clear outside the timed states so each phase starts from zero.
  always_comb begin
    cnt_clr   = 1'b1;
    idx_clr   = 1'b0;
    shift_en  = 1'b0;
    rx_push   = 1'b0;
    frame_set = 1'b0;
    case (state)
      S_START: begin
        cnt_clr = tick_half;
        idx_clr = tick_half;
      end
      S_DATA: begin
        cnt_clr  = tick_bit;
        shift_en = tick_bit;
      end
      S_STOP: begin
        cnt_clr   = tick_bit;
        rx_push   = tick_bit && rx_sync;
        frame_set = tick_bit && !rx_sync;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clr) cnt <= '0;
      else         cnt <= cnt + 1'b1;
      if (idx_clr) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {rx_sync, shreg[7:1]};
      end
    end
  end

  assign bus_access   = sel && !ready;
  assign bus_read     = bus_access && (wstrb == 4'b0000);
  assign bus_write_lo = bus_access && wstrb[0];
  assign reg_sel      = address[3:2];

  assign fifo_full   = (count == CW'(FIFO_DEPTH));
  assign not_empty   = (count != '0);
  assign pop         = bus_read && (reg_sel == 2'd0) && not_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign push        = rx_push && (!fifo_full || pop);
  assign overrun_set = rx_push && fifo_full && !pop;
  assign w1c         = bus_write_lo && (reg_sel == 2'd1);

  always_ff @(posedge clk_cpu) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      overrun   <= overrun_set || (overrun && !(w1c && wdata[2]));
      frame_err <= frame_set || (frame_err && !(w1c && wdata[3]));
      if (bus_write_lo && reg_sel == 2'd2) irq_en <= wdata[0];
    end
  end

  // Count field is 8 bits wide; at depth 256 a full FIFO reads count 0 with full set.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd0: if (not_empty) rd_mux = {23'b0, 1'b1, mem[rd_ptr]};
      2'd1: rd_mux = {16'b0, 8'(count), 4'b0, frame_err, overrun, fifo_full, not_empty};
      2'd2: rd_mux = {31'b0, irq_en};
      default: ;
    endcase
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= bus_access;
      if (bus_access) rdata <= bus_read ? rd_mux : '0;
    end
  end

  assign irq = irq_en && (not_empty || overrun || frame_err);

  assign unused_bits = ^{address[1:0], wdata[31:4], wdata[1], wstrb[3:1]};

endmodule

// File: tb/tb_soc_uart_rx.sv
// Directed bench for soc_uart_rx: 8N1 frames at 234 clocks per bit, bus reads/writes
// of DATA/STATUS/CTRL, overrun, framing error, glitch and full-FIFO push/pop overlap.
module tb_soc_uart_rx;

  localparam int unsigned CPB = 234;
  // Push edge counted from the first posedge after the start bit is driven:
  // 2 sync + 117 half bit + 8*234 data + 234 stop.
  localparam int unsigned PUSH_EDGE = 2225;

  localparam logic [3:0] A_DATA   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_CTRL   = 4'h8;

  logic        clk_cpu = 1'b0;
  logic        n_reset;
  logic        rx_pin;
  logic        sel;
  logic [3:0]  wstrb;
  logic [3:0]  address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  soc_uart_rx #(
    .UART_CLK_HZ(27000000),
    .BAUD_RATE  (115200),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_cpu(clk_cpu),
    .n_reset(n_reset),
    .rx_pin (rx_pin),
    .sel    (sel),
    .wstrb  (wstrb),
    .address(address),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .irq    (irq)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk_cpu);
  endtask

  // Entered and left just after a negedge.
  task automatic bus(input logic [3:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd, output logic [31:0] rd);
    sel     = 1'b1;
    address = addr;
    wstrb   = strb;
    wdata   = wd;
    @(negedge clk_cpu);
    check("ready_high", 32'(ready), 32'd1);
    rd      = rdata;
    sel     = 1'b0;
    wstrb   = 4'b0000;
    wdata   = '0;
    @(negedge clk_cpu);
    check("ready_one_cycle", 32'(ready), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_pin = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      idle(CPB);
    end
    rx_pin = stop_bit;
    idle(CPB);
    rx_pin = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] d_timed;
    n_reset = 1'b0;
    rx_pin  = 1'b1;
    sel     = 1'b0;
    wstrb   = 4'b0000;
    address = '0;
    wdata   = '0;
    idle(4);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_irq",   32'(irq),   32'd0);
    check("rst_rdata", rdata,      32'd0);
    n_reset = 1'b1;
    idle(4);

    bus(A_STATUS, 4'b0000, '0, d); check("rst_status", d, 32'h0000_0000);
    bus(A_DATA,   4'b0000, '0, d); check("rst_data",   d, 32'h0000_0000);
    bus(A_STATUS, 4'b0000, '0, d); check("empty_pop",  d, 32'h0000_0000);
    bus(A_CTRL,   4'b0000, '0, d); check("rst_ctrl",   d, 32'h0000_0000);

    // Single byte
    send_frame(8'hA5, 1'b1);
    idle(10);
    bus(A_STATUS, 4'b0000, '0, d); check("a5_status",  d, 32'h0000_0101);
    bus(A_DATA,   4'b0000, '0, d); check("a5_data",    d, 32'h0000_01A5);
    bus(A_STATUS, 4'b0000, '0, d); check("a5_drained", d, 32'h0000_0000);

    // Glitch shorter than half a bit
    rx_pin = 1'b0;
    idle(50);
    rx_pin = 1'b1;
    idle(300);
    bus(A_STATUS, 4'b0000, '0, d); check("glitch_status", d, 32'h0000_0000);

    // Framing error, then a good byte
    send_frame(8'h3C, 1'b0);
    idle(20);
    bus(A_STATUS, 4'b0000, '0, d); check("ferr_status", d, 32'h0000_0008);
    check("ferr_irq_off", 32'(irq), 32'd0);
    send_frame(8'h55, 1'b1);
    idle(10);
    bus(A_STATUS, 4'b0000, '0, d); check("ferr_then_55", d, 32'h0000_0109);
    bus(A_DATA,   4'b0000, '0, d); check("data_55",      d, 32'h0000_0155);
    bus(A_STATUS, 4'b0000, 32'h8, d);
    bus(A_STATUS, 4'b0000, '0, d); check("ferr_sticky_read", d, 32'h0000_0008);
    bus(A_STATUS, 4'b0001, 32'h8, d);
    bus(A_STATUS, 4'b0000, '0, d); check("ferr_cleared", d, 32'h0000_0000);

    // Overrun
    bus(A_CTRL, 4'b0001, 32'h1, d);
    bus(A_CTRL, 4'b0000, '0, d); check("ctrl_irq_en", d, 32'h0000_0001);
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    idle(10);
    bus(A_STATUS, 4'b0000, '0, d); check("ovr_status", d, 32'h0000_1007);
    check("ovr_irq", 32'(irq), 32'd1);
    bus(A_STATUS, 4'b0001, 32'h4, d);
    bus(A_STATUS, 4'b0000, '0, d); check("ovr_cleared_full", d, 32'h0000_1003);
    check("irq_not_empty", 32'(irq), 32'd1);

    // Full FIFO: DATA pop lands on the same edge as the STOP push
    fork
      send_frame(8'h11, 1'b1);
      begin
        idle(PUSH_EDGE);
        bus(A_DATA, 4'b0000, '0, d_timed);
      end
    join
    check("timed_pop", d_timed, 32'h0000_0100);
    idle(10);
    bus(A_STATUS, 4'b0000, '0, d); check("pushpop_status", d, 32'h0000_1003);

    for (int i = 1; i < 17; i++) begin
      bus(A_DATA, 4'b0000, '0, d);
      check("drain", d, (i < 16) ? (32'h100 | 32'(i)) : 32'h0000_0111);
    end
    bus(A_STATUS, 4'b0000, '0, d); check("drained_status", d, 32'h0000_0000);
    check("drained_irq", 32'(irq), 32'd0);
    bus(A_DATA, 4'b0000, '0, d); check("drained_data", d, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
